// File: rtl/serial_tx_frame.sv
// serial_tx_frame: transmit end of the oversampled serial link.
// Frames a parallel word LSB-first as start(0), data bits, [parity], stop(1).
// Each bit is held for TICKS_PER_BIT pulses of the shared oversample tick.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | line high, ready for a word, tick counter held at 0
// START   | start bit (0) on the line
// DATA    | shift register bit 0 on the line, LSB first
// PARITY  | even parity of the latched word (only with the option)
// STOP    | stop bit (1) on the line; done pulses when it completes
module serial_tx_frame #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 tx_out_nxt;
  logic                 accept;
  logic                 bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // tx_ready is only ever high in IDLE, so this is the acceptance condition
  assign accept  = tx_valid && tx_ready;

  // the current serial bit finishes on the tick that completes its count
  assign bit_end = (state != S_IDLE) && tick && (tick_cnt == TICK_LAST);

  // next-state decode for the frame sequence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == IDX_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // shift register next value: load on accept, shift once per data bit
  always_comb begin
    shift_nxt = shift_reg;
    if (accept) begin
      shift_nxt = tx_data;
    end else if ((state == S_DATA) && bit_end) begin
      shift_nxt = shift_reg >> 1;
    end
  end

  // line level for the state being entered, so tx_out can be registered
  always_comb begin
    tx_out_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   tx_out_nxt = 1'b1;
      S_START:  tx_out_nxt = 1'b0;
      S_DATA:   tx_out_nxt = shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_out_nxt = parity_bit;
`endif
      S_STOP:   tx_out_nxt = 1'b1;
      default:  tx_out_nxt = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // oversample tick counter; held at 0 in IDLE so each frame starts aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= '0;
    end else if (tick) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // data bit index, only meaningful while in DATA
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (state != S_DATA) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // payload shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_nxt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // even parity of the whole word, captured before any shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  // registered outputs; done, busy and tx_ready all change on the stop-bit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_out   <= tx_out_nxt;
      tx_ready <= (state_nxt == S_IDLE);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state == S_STOP) && bit_end;
    end
  end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: directed scenarios plus randomized frames,
// every output compared each cycle against a queue-of-bits line model.
module tb_serial_tx_frame;

  localparam int DATA_BITS = 8;
  localparam int TPB       = 16;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_mode = 0;   // 0: every cycle, N>0: every Nth cycle, -1: random

  bit mq[$];           // bits still to appear on the line, head = current bit
  int m_tcnt = 0;
  bit m_done = 1'b0;

  serial_tx_frame #(.DATA_BITS(DATA_BITS), .TICKS_PER_BIT(TPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void load_frame(input logic [7:0] d);
    mq.delete();
    mq.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) mq.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    mq.push_back(^d);
`endif
    mq.push_back(1'b1);
  endfunction

  // one clock edge of the reference: a frame is a list of bits, each consuming TPB ticks
  task automatic model_edge();
    bit dummy;
    if (rst) begin
      mq.delete();
      m_tcnt = 0;
      m_done = 1'b0;
    end else if (mq.size() == 0) begin
      m_done = 1'b0;
      if (tx_valid) begin
        load_frame(tx_data);
        m_tcnt = 0;
      end
    end else begin
      m_done = 1'b0;
      if (tick) begin
        m_tcnt++;
        if (m_tcnt == TPB) begin
          m_tcnt = 0;
          dummy = mq.pop_front();
          if (mq.size() == 0) m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    if (tick_mode == 0)       tick = 1'b1;
    else if (tick_mode < 0)   tick = 1'($urandom_range(0, 1));
    else                      tick = ((cyc % tick_mode) == 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("tx_out",   tx_out,   (mq.size() != 0) ? 32'(mq[0]) : 32'd1);
    check_val("tx_ready", tx_ready, (mq.size() == 0) ? 32'd1 : 32'd0);
    check_val("busy",     busy,     (mq.size() != 0) ? 32'd1 : 32'd0);
    check_val("done",     done,     32'(m_done));
    cyc++;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit noise);
    int n = 0;
    while (mq.size() != 0 && n < max_cyc) begin
      if (noise && mq.size() > 1) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
      step();
      n++;
    end
    tx_valid = 1'b0;
    if (mq.size() != 0) check_val("idle_timeout", 32'(n), 32'(max_cyc + 1));
  endtask

  // steps until the DUT reports done; returns cycles since the start-bit cycle
  task automatic run_to_done(output int n, output logic par_obs);
    n = 0;
    par_obs = 1'bx;
    do begin
      step();
      n++;
      if (n == (DATA_BITS + 1) * TPB) par_obs = tx_out;
    end while (done !== 1'b1 && n < 2000);
  endtask

  initial begin
    int n;
    logic par_obs;

    // reset held two cycles with tick high
    tick_mode = 0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();

    // single frame A5, tick every cycle, done latency
    send(8'hA5);
    check_val("a5_start_low", tx_out, 32'd0);
    run_to_done(n, par_obs);
    check_val("a5_done_lat", 32'(n), 32'(FRAME_BITS * TPB));
    step();

    // tick every 4th cycle, word 01
    tick_mode = 4;
    send(8'h01);
    wait_idle(4000, 1'b0);
    step();

    // back-to-back with tx_valid held high
    tick_mode = 0;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    step();
    tx_data  = 8'hFF;
    run_to_done(n, par_obs);
    check_val("b2b_done_lat", 32'(n), 32'(FRAME_BITS * TPB));
    check_val("b2b_gap_high", tx_out, 32'd1);
    step();
    check_val("b2b_start_low", tx_out, 32'd0);
    tx_valid = 1'b0;
    wait_idle(4000, 1'b1);
    step();

    // reset during data bit 3 of word 00, then a clean frame 3C
    send(8'h00);
    repeat (TPB + 3 * TPB + 5) step();
    rst = 1'b1;
    step();
    check_val("mid_rst_tx_out", tx_out, 32'd1);
    check_val("mid_rst_ready",  tx_ready, 32'd1);
    rst = 1'b0;
    repeat (20) step();
    send(8'h3C);
    wait_idle(4000, 1'b0);
    step();

`ifdef SERIAL_TX_PARITY_EN
    send(8'h07);
    run_to_done(n, par_obs);
    check_val("par07_bit", par_obs, 32'd1);
    check_val("par07_lat", 32'(n), 32'(FRAME_BITS * TPB));
    step();
    send(8'h03);
    run_to_done(n, par_obs);
    check_val("par03_bit", par_obs, 32'd0);
    step();
`endif

    // randomized frames: random words, tick patterns, valid noise, resets
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0: tick_mode = 0;
        1: tick_mode = 2;
        2: tick_mode = 3;
        default: tick_mode = -1;
      endcase
      send(8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 150)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      wait_idle(8000, 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
